// File: rtl/mfi_check_sequencer.sv
// -----------------------------------------------------------------------------
// mfi_check_sequencer
//
// Per-property controller for the MFI formal harness. After reset_n releases
// it holds the DUT in reset for RESET_CYCLES cycles and then lets it run. At
// run-cycle CHECK_CYCLE it pulses `check` for one cycle to every attached
// checker. It also supervises the retirement stream: it counts retirements,
// flags order gaps or repeats, and records whether target_order has retired.
//
// Ports
//   clock        in   1        sole clock
//   reset_n      in   1        asynchronous active-low reset
//   mfi_valid    in   1        retirement valid from the DUT MFI port
//   mfi_order    in   ORDER_W  retirement order from the DUT MFI port
//   target_order in   ORDER_W  order of the instruction under check
//   dut_reset    out  1        active-high synchronous reset to the DUT
//   check        out  1        one-cycle strobe to the checkers
//   run_cycle    out  CYC_W    cycles since dut_reset deasserted, saturating
//   retire_cnt   out  ORDER_W  retirements seen since dut_reset deasserted
//   target_seen  out  1        sticky: target_order has retired
//   order_err    out  1        sticky: retirement stream skipped/repeated
//   done         out  1        sticky: check has fired
// -----------------------------------------------------------------------------
module mfi_check_sequencer #(
  parameter int unsigned RESET_CYCLES = 2,   // 1..255
  parameter int unsigned CHECK_CYCLE  = 20,  // >= 1
  parameter int unsigned ORDER_W      = 64,
  parameter int unsigned CYC_W        = 16   // must hold CHECK_CYCLE
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               mfi_valid,
  input  logic [ORDER_W-1:0] mfi_order,
  input  logic [ORDER_W-1:0] target_order,
  output logic               dut_reset,
  output logic               check,
  output logic [CYC_W-1:0]   run_cycle,
  output logic [ORDER_W-1:0] retire_cnt,
  output logic               target_seen,
  output logic               order_err,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Last hold-counter value before leaving HOLD, and last RUN cycle index.
  localparam logic [7:0]       HOLD_LAST  = 8'(RESET_CYCLES - 1);
  localparam logic [CYC_W-1:0] CHECK_LAST = CYC_W'(CHECK_CYCLE - 1);

  state_e             state_q;
  logic [7:0]         hold_cnt_q;
  logic [CYC_W-1:0]   run_cycle_q;
  logic               dut_reset_q;
  logic               check_q;
  logic               done_q;

  logic [ORDER_W-1:0] retire_cnt_q,  retire_cnt_d;
  logic [ORDER_W-1:0] expected_q,    expected_d;
  logic               order_err_q,   order_err_d;
  logic               target_seen_q, target_seen_d;

  logic [CYC_W-1:0]   run_cycle_inc;

  // run_cycle sticks at all-ones instead of wrapping.
  assign run_cycle_inc = (run_cycle_q == '1) ? run_cycle_q
                                             : run_cycle_q + CYC_W'(1);

  // ---------------------------------------------------------------------------
  // Sequencing FSM. Every output is decoded one cycle early and registered so
  // dut_reset and check come straight from flops and cannot glitch.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking (<=) assignments
  // so every flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      run_cycle_q <= '0;
      dut_reset_q <= 1'b1;
      check_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          hold_cnt_q <= hold_cnt_q + 8'd1;
          if (hold_cnt_q == HOLD_LAST) begin
            state_q     <= ST_RUN;
            dut_reset_q <= 1'b0;
          end
        end
        ST_RUN: begin
          run_cycle_q <= run_cycle_inc;
          if (run_cycle_q == CHECK_LAST) begin
            state_q <= ST_CHECK;
            check_q <= 1'b1;
          end
        end
        ST_CHECK: begin
          run_cycle_q <= run_cycle_inc;
          state_q     <= ST_DONE;
          check_q     <= 1'b0;
          done_q      <= 1'b1;
        end
        ST_DONE: begin
          run_cycle_q <= run_cycle_inc;
        end
        default: begin
          state_q     <= ST_HOLD;
          hold_cnt_q  <= '0;
          run_cycle_q <= '0;
          dut_reset_q <= 1'b1;
          check_q     <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Retirement supervision, live only once the DUT is out of reset. Whether
  // the order matched or not, the next expected order is mfi_order+1, so a
  // single gap raises one error and the stream is then tracked from there.
  // ---------------------------------------------------------------------------
  // NOTE: every _d signal gets its default first, so no path through this
  // block leaves a value unassigned and no latch is inferred.
  always_comb begin
    retire_cnt_d  = retire_cnt_q;
    expected_d    = expected_q;
    order_err_d   = order_err_q;
    target_seen_d = target_seen_q;
    if (state_q == ST_HOLD) begin
      retire_cnt_d  = '0;
      expected_d    = '0;
      order_err_d   = 1'b0;
      target_seen_d = 1'b0;
    end else if (mfi_valid) begin
      retire_cnt_d = retire_cnt_q + ORDER_W'(1);
      expected_d   = mfi_order + ORDER_W'(1);
      if (mfi_order != expected_q) begin
        order_err_d = 1'b1;
      end
      if (mfi_order == target_order) begin
        target_seen_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retire_cnt_q  <= '0;
      expected_q    <= '0;
      order_err_q   <= 1'b0;
      target_seen_q <= 1'b0;
    end else begin
      retire_cnt_q  <= retire_cnt_d;
      expected_q    <= expected_d;
      order_err_q   <= order_err_d;
      target_seen_q <= target_seen_d;
    end
  end

  assign dut_reset   = dut_reset_q;
  assign check       = check_q;
  assign run_cycle   = run_cycle_q;
  assign retire_cnt  = retire_cnt_q;
  assign target_seen = target_seen_q;
  assign order_err   = order_err_q;
  assign done        = done_q;

endmodule
